lcd_message_sequencer: RTL and testbench

Sequencer that sits in front of `LCD_controller` and owns its `LCD_start`/`LCD_instruction`/`LCD_done` handshake. Out of reset it issues the 16x2 character-LCD initialisation commands. It then writes a 32-character screen buffer (two lines of 16) to the display, and repeats that write whenever a refresh is requested. User logic writes characters into the buffer through a simple write port and never talks to the LCD controller directly.

---
 rtl/lcd_message_sequencer.sv | 128 ++++++++++++
 tb/tb_lcd_message_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_message_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lcd_message_sequencer                                                  |
// | Issues 16x2 LCD init, then writes a 32-char buffer on each refresh.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module lcd_message_sequencer #(
  parameter logic [8:0] LINE1_ADDR = 9'h080,
  parameter logic [8:0] LINE2_ADDR = 9'h0C0
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       Refresh,
  input  logic       Char_we,
  input  logic [4:0] Char_addr,
  input  logic [7:0] Char_data,
  output logic       Busy,
  output logic       Init_done,
  output logic       LCD_start,
  output logic [8:0] LCD_instruction,
  input  logic       LCD_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ASSERT    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [5:0] C_LAST_STEP   = 6'd37;
  localparam logic [5:0] C_REFRESH_STEP = 6'd4;

  state_t     r_state;
  logic [5:0] r_step;
  logic       r_pending;
  logic [7:0] r_buf [32];
  logic [4:0] w_buf_idx;
  logic [8:0] w_table;
  logic       w_pass_start;

  assign w_pass_start = (r_state == S_IDLE) && r_pending;

  always_comb begin
    w_buf_idx = 5'd0;
    if (r_step <= 6'd20) w_buf_idx = 5'(r_step - 6'd5);
    else                 w_buf_idx = 5'(r_step - 6'd6);
  end

  always_comb begin
    w_table = {1'b1, r_buf[w_buf_idx]};
    case (r_step)
      6'd0:    w_table = 9'h038;
      6'd1:    w_table = 9'h00C;
      6'd2:    w_table = 9'h001;
      6'd3:    w_table = 9'h006;
      6'd4:    w_table = LINE1_ADDR;
      6'd21:   w_table = LINE2_ADDR;
      default: w_table = {1'b1, r_buf[w_buf_idx]};
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else if (Char_we) begin
      r_buf[Char_addr] <= Char_data;
    end
  end

  // A refresh arriving in the same cycle as a pass start keeps pending set.
  always_ff @(posedge Clock_50) begin
    if (Reset) r_pending <= 1'b0;
    else       r_pending <= Refresh | (r_pending & ~w_pass_start);
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      r_state         <= S_LOAD;
      r_step          <= 6'd0;
      LCD_start       <= 1'b0;
      LCD_instruction <= 9'h000;
      Busy            <= 1'b1;
      Init_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_step  <= C_REFRESH_STEP;
            Busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          LCD_instruction <= w_table;
          LCD_start       <= 1'b0;
          r_state         <= S_ASSERT;
        end
        S_ASSERT: begin
          // Wait for the previous instruction's done level to clear.
          LCD_start <= 1'b1;
          if (!LCD_done) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (LCD_done) begin
            LCD_start <= 1'b0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          LCD_start <= 1'b0;
          if (r_step == 6'd3) Init_done <= 1'b1;
          if (r_step == C_LAST_STEP) begin
            Busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_step  <= r_step + 6'd1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_message_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lcd_message_sequencer                                               |
// | Directed bench with a behavioural LCD controller (20-cycle done).     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_lcd_message_sequencer;

  logic       Clock_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       Refresh = 1'b0;
  logic       Char_we = 1'b0;
  logic [4:0] Char_addr = 5'd0;
  logic [7:0] Char_data = 8'd0;
  logic       Busy, Init_done, LCD_start, LCD_done;
  logic [8:0] LCD_instruction;

  int n_cmp = 0;
  int n_fail = 0;

  always #10 Clock_50 = ~Clock_50;

  lcd_message_sequencer dut (
    .Clock_50(Clock_50), .Reset(Reset), .Refresh(Refresh),
    .Char_we(Char_we), .Char_addr(Char_addr), .Char_data(Char_data),
    .Busy(Busy), .Init_done(Init_done), .LCD_start(LCD_start),
    .LCD_instruction(LCD_instruction), .LCD_done(LCD_done)
  );

  // Controller model: done drops after a start rise (optionally delayed), rises 20 cycles later.
  logic       m_prev_start = 1'b0;
  bit         m_busy = 1'b0;
  int         m_cnt = 0, m_hold = 0, hold_delay = 0;
  logic [8:0] log_q[$];

  always @(posedge Clock_50) begin
    m_prev_start <= LCD_start;
    if (Reset) begin
      LCD_done <= 1'b0; m_busy <= 1'b0; m_cnt <= 0; m_hold <= 0;
    end else if (LCD_start && !m_prev_start) begin
      log_q.push_back(LCD_instruction);
      m_busy <= 1'b1; m_hold <= hold_delay; m_cnt <= 20;
      if (hold_delay == 0) LCD_done <= 1'b0;
    end else if (m_busy) begin
      if (m_hold != 0) begin
        m_hold <= m_hold - 1;
        if (m_hold == 1) LCD_done <= 1'b0;
      end else begin
        if (m_cnt == 1) begin LCD_done <= 1'b1; m_busy <= 1'b0; end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Handshake monitor, sampled on the falling edge.
  bit         mon_en = 1'b1;
  logic       mp_s = 1'b0, mp_d = 1'b0, mp_init = 1'b0;
  logic [8:0] mp_i = 9'h000, cap = 9'h000;
  int         viol = 0, low_cnt = 0, high_cnt = 0, min_high = 999, init_rise_at = -1;

  always @(negedge Clock_50) begin
    if (mon_en) begin
      if (LCD_start && !mp_s) begin
        if (LCD_instruction !== mp_i) viol++;
        if (low_cnt < 2) viol++;
        cap = LCD_instruction;
      end
      if (LCD_start && LCD_instruction !== cap) viol++;
      if (!LCD_start && mp_s) begin
        if (LCD_instruction !== cap) viol++;
        if (!mp_d || m_busy) viol++;
        if (high_cnt < min_high) min_high = high_cnt;
      end
    end
    if (LCD_start) begin high_cnt++; low_cnt = 0; end
    else begin low_cnt++; high_cnt = 0; end
    if (Init_done && !mp_init) init_rise_at = log_q.size();
    mp_s = LCD_start; mp_i = LCD_instruction; mp_d = LCD_done; mp_init = Init_done;
  end

  logic [7:0] tb_buf [32];

  function automatic logic [8:0] exp_step(input int s);
    case (s)
      0: return 9'h038;
      1: return 9'h00C;
      2: return 9'h001;
      3: return 9'h006;
      4: return 9'h080;
      21: return 9'h0C0;
      default: return (s <= 20) ? {1'b1, tb_buf[s-5]} : {1'b1, tb_buf[s-6]};
    endcase
  endfunction

  task automatic wait_busy(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock_50);
      if (Busy === lvl) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_refresh();
    @(negedge Clock_50); Refresh = 1'b1;
    @(negedge Clock_50); Refresh = 1'b0;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    @(negedge Clock_50); Char_we = 1'b1; Char_addr = a; Char_data = d;
    @(negedge Clock_50); Char_we = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock_50);
    n_cmp++; if (LCD_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", LCD_start); end
    n_cmp++; if (LCD_instruction !== 9'h000) begin n_fail++; $display("FAIL reset_instr got %h want 000", LCD_instruction); end
    n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", Busy); end
    n_cmp++; if (Init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", Init_done); end
    init_rise_at = -1;
    Reset = 1'b0;
  endtask

  task automatic test_init();
    bit ok;
    wait_busy(1'b0, 3000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL init_timeout got busy=%b want 0", Busy); end
    n_cmp++; if (log_q.size() != 38) begin n_fail++; $display("FAIL init_count got %0d want 38", log_q.size()); end
    n_cmp++; if (init_rise_at != 4) begin n_fail++; $display("FAIL init_done_rise got %0d want 4", init_rise_at); end
    n_cmp++; if (Init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_level got %b want 1", Init_done); end
    for (int k = 0; k < 38 && k < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[k] !== exp_step(k)) begin n_fail++; $display("FAIL init_instr[%0d] got %h want %h", k, log_q[k], exp_step(k)); end
    end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL init_handshake got %0d violations want 0", viol); end
  endtask

  task automatic test_hello();
    bit ok;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) begin
      write_char(5'(i), hello[i]);
      tb_buf[i] = hello[i];
    end
    log_q.delete();
    pulse_refresh();
    wait_busy(1'b1, 10, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL hello_busy_rise got %b want 1", Busy); end
    wait_busy(1'b0, 2000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL hello_timeout got busy=%b want 0", Busy); end
    n_cmp++; if (log_q.size() != 34) begin n_fail++; $display("FAIL hello_count got %0d want 34", log_q.size()); end
    n_cmp++; if (log_q.size() > 5 && log_q[5] !== 9'h14F) begin n_fail++; $display("FAIL hello_O got %h want 14F", log_q[5]); end
    for (int k = 0; k < 34 && k < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[k] !== exp_step(k + 4)) begin n_fail++; $display("FAIL hello_instr[%0d] got %h want %h", k, log_q[k], exp_step(k + 4)); end
    end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL hello_handshake got %0d violations want 0", viol); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    log_q.delete();
    pulse_refresh();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock_50);
      if (log_q.size() >= 12) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_progress got %0d want >=12", log_q.size()); end
    write_char(5'd0, 8'h5A);
    for (int p = 0; p < 3; p++) begin
      pulse_refresh();
      repeat (40) @(negedge Clock_50);
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock_50);
      if (log_q.size() >= 68) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_second_pass got %0d want 68", log_q.size()); end
    wait_busy(1'b0, 200, ok);
    repeat (300) @(negedge Clock_50);
    n_cmp++; if (log_q.size() != 68) begin n_fail++; $display("FAIL b2b_count got %0d want 68", log_q.size()); end
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", Busy); end
    n_cmp++; if (log_q.size() > 1 && log_q[1] !== 9'h148) begin n_fail++; $display("FAIL b2b_old_char got %h want 148", log_q[1]); end
    tb_buf[0] = 8'h5A;
    for (int k = 0; k < 34 && k + 34 < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[k + 34] !== exp_step(k + 4)) begin n_fail++; $display("FAIL b2b_instr[%0d] got %h want %h", k + 34, log_q[k + 34], exp_step(k + 4)); end
    end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL b2b_handshake got %0d violations want 0", viol); end
  endtask

  task automatic test_done_hold();
    bit ok;
    hold_delay = 5;
    min_high = 999;
    log_q.delete();
    pulse_refresh();
    wait_busy(1'b1, 10, ok);
    wait_busy(1'b0, 2500, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL hold_timeout got busy=%b want 0", Busy); end
    n_cmp++; if (log_q.size() != 34) begin n_fail++; $display("FAIL hold_count got %0d want 34", log_q.size()); end
    n_cmp++; if (min_high < 25) begin n_fail++; $display("FAIL hold_start_high got %0d cycles want >=25", min_high); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL hold_handshake got %0d violations want 0", viol); end
    hold_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    log_q.delete();
    pulse_refresh();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clock_50);
      if (log_q.size() >= 9) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_progress got %0d want 9", log_q.size()); end
    mon_en = 1'b0;
    Reset = 1'b1;
    @(negedge Clock_50);
    n_cmp++; if (LCD_start !== 1'b0) begin n_fail++; $display("FAIL rmid_start got %b want 0", LCD_start); end
    n_cmp++; if (LCD_instruction !== 9'h000) begin n_fail++; $display("FAIL rmid_instr got %h want 000", LCD_instruction); end
    n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b want 1", Busy); end
    n_cmp++; if (Init_done !== 1'b0) begin n_fail++; $display("FAIL rmid_init_done got %b want 0", Init_done); end
    Reset = 1'b0;
    log_q.delete();
    init_rise_at = -1;
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    @(negedge Clock_50);
    mon_en = 1'b1;
    wait_busy(1'b0, 3000, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout got busy=%b want 0", Busy); end
    n_cmp++; if (log_q.size() != 38) begin n_fail++; $display("FAIL rmid_count got %0d want 38", log_q.size()); end
    n_cmp++; if (log_q.size() > 0 && log_q[0] !== 9'h038) begin n_fail++; $display("FAIL rmid_first got %h want 038", log_q[0]); end
    n_cmp++; if (init_rise_at != 4) begin n_fail++; $display("FAIL rmid_init_rise got %0d want 4", init_rise_at); end
    for (int k = 0; k < 38 && k < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[k] !== exp_step(k)) begin n_fail++; $display("FAIL rmid_instr[%0d] got %h want %h", k, log_q[k], exp_step(k)); end
    end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL rmid_handshake got %0d violations want 0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
    test_reset();
    test_init();
    test_hello();
    test_back_to_back();
    test_done_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
